// File: rtl/music_player_param.sv
// -----------------------------------------------------------------------------
// music_player_param
//
// Purpose:
//    Song sequencer and square-wave tone generator in one block. The sequencer
//    fetches 32-bit note words from song memory one at a time. It plays each
//    note for note_duration * M cycles, then moves to the next slot. Playback
//    can be paused and resumed. At the end of a song the block either loops
//    back to slot 0 or pulses song_done and returns to IDLE.
//
//    Note word: [3:0] note index (0 or > NUM_NOTES is a rest),
//               [11:8] duration multiplier M (0 means 1),
//               [31] end-of-song marker; all other bits are don't-care.
//
// Ports:
//    clk, rst       clock, asynchronous active-high reset
//    song_sel       song number, captured when a start is accepted in IDLE
//    start_song     start request (ignored outside IDLE)
//    pause          level; freezes playback while in PLAY/PAUSED
//    loop_en        level; sampled at the end of a song
//    note_periods   packed half-periods, note k at [k*PERIOD_W-1 -: PERIOD_W]
//    note_duration  cycles per duration unit (0 means 1)
//    state          FSM state code (IDLE=0 FETCH=1 WAIT=2 PLAY=3 PAUSED=4)
//    idle           high while in IDLE
//    song_done      one-cycle pulse, first IDLE cycle after a non-looping end
//    note_sel       current note index in PLAY/PAUSED, 0 elsewhere and for rests
//    note           square-wave output, only active in PLAY
//    memreq_val     read request, high for the single FETCH cycle
//    memreq_addr    read address {song, idx}, zero extended; holds between fetches
//    memresp_data   read data, valid in the cycle after memreq_val
// -----------------------------------------------------------------------------
module music_player_param #(
   parameter int NUM_NOTES      = 7,
   parameter int PERIOD_W       = 8,
   parameter int DUR_W          = 16,
   parameter int NOTES_PER_SONG = 32,
   parameter int SONG_W         = 5,
   parameter int ADDR_W         = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SONG_W-1:0]             song_sel,
   input  logic                          start_song,
   input  logic                          pause,
   input  logic                          loop_en,
   input  logic [NUM_NOTES*PERIOD_W-1:0] note_periods,
   input  logic [DUR_W-1:0]              note_duration,
   output logic [2:0]                    state,
   output logic                          idle,
   output logic                          song_done,
   output logic [3:0]                    note_sel,
   output logic                          note,
   output logic                          memreq_val,
   output logic [ADDR_W-1:0]             memreq_addr,
   input  logic [31:0]                   memresp_data
);

   localparam int IDX_W = $clog2(NOTES_PER_SONG);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_PLAY   = 3'd3;
   localparam logic [2:0] ST_PAUSED = 3'd4;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES_PER_SONG - 1);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [2:0]          state_q,     state_d;
   logic [SONG_W-1:0]   song_q,      song_d;
   logic [IDX_W-1:0]    idx_q,       idx_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic                song_done_q, song_done_d;
   logic [3:0]          note_idx_q,  note_idx_d;
   logic [3:0]          mult_q,      mult_d;
   logic [DUR_W-1:0]    unit_cnt_q,  unit_cnt_d;
   logic [3:0]          mult_cnt_q,  mult_cnt_d;
   logic [PERIOD_W-1:0] tone_cnt_q,  tone_cnt_d;
   logic                phase_q,     phase_d;

   // ------------------------------------------------------------------
   // Half-period lookup: entry 0 and entries above NUM_NOTES read as 0,
   // so rests fall out of the same "period == 0 means silence" rule.
   // ------------------------------------------------------------------
   logic [PERIOD_W-1:0] period_tab [16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_period
         if (gi >= 1 && gi <= NUM_NOTES) begin : g_note
            assign period_tab[gi] = note_periods[gi*PERIOD_W-1 -: PERIOD_W];
         end else begin : g_rest
            assign period_tab[gi] = '0;
         end
      end
   endgenerate

   logic [PERIOD_W-1:0] period_cur;
   assign period_cur = period_tab[note_idx_q];

   // ------------------------------------------------------------------
   // Note word decode (only meaningful in WAIT)
   // ------------------------------------------------------------------
   logic [3:0] word_idx;
   logic [3:0] word_mult;
   logic       word_end;
   logic       word_is_note;

   assign word_idx     = memresp_data[3:0];
   assign word_mult    = memresp_data[11:8];
   assign word_end     = memresp_data[31];
   assign word_is_note = (word_idx != 4'd0) && ({28'd0, word_idx} <= 32'(NUM_NOTES));

   // Bits of the note word that carry no meaning.
   logic unused_resp_bits;
   assign unused_resp_bits = ^{memresp_data[30:12], memresp_data[7:4]};

   // ------------------------------------------------------------------
   // Duration bookkeeping. A note ends on the cycle where both the unit
   // counter and the multiplier counter sit on their last value, giving
   // exactly dur_eff * mult_q PLAY cycles.
   // ------------------------------------------------------------------
   logic [DUR_W-1:0] dur_eff;
   logic             unit_last;
   logic             mult_last;
   logic             note_expire;
   logic             last_slot;

   assign dur_eff     = (note_duration == '0) ? DUR_W'(1) : note_duration;
   assign unit_last   = (unit_cnt_q == dur_eff - DUR_W'(1));
   assign mult_last   = (mult_cnt_q == mult_q - 4'd1);
   assign note_expire = (state_q == ST_PLAY) && unit_last && mult_last;
   assign last_slot   = (idx_q == IDX_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_song) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (word_end) state_d = loop_en ? ST_FETCH : ST_IDLE;
            else          state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // Note expiry wins over a simultaneous pause request: the
            // note is finished, so there is nothing left to freeze.
            if (note_expire) begin
               if (last_slot) state_d = loop_en ? ST_FETCH : ST_IDLE;
               else           state_d = ST_FETCH;
            end else if (pause) begin
               state_d = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (!pause) state_d = ST_PLAY;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next values
   // ------------------------------------------------------------------
   always_comb begin
      song_d      = song_q;
      idx_d       = idx_q;
      song_done_d = 1'b0;
      note_idx_d  = note_idx_q;
      mult_d      = mult_q;
      unit_cnt_d  = unit_cnt_q;
      mult_cnt_d  = mult_cnt_q;
      tone_cnt_d  = tone_cnt_q;
      phase_d     = phase_q;

      case (state_q)
         ST_IDLE: begin
            if (start_song) begin
               song_d = song_sel;
               idx_d  = '0;
            end
         end

         ST_WAIT: begin
            if (word_end) begin
               if (loop_en) idx_d       = '0;
               else         song_done_d = 1'b1;
            end else begin
               // Rests are stored as index 0 so note_sel reads 0 for them.
               note_idx_d = word_is_note ? word_idx : 4'd0;
               mult_d     = (word_mult == 4'd0) ? 4'd1 : word_mult;
               unit_cnt_d = '0;
               mult_cnt_d = '0;
               tone_cnt_d = '0;
               phase_d    = 1'b0;
            end
         end

         ST_PLAY: begin
            // Tone generator: count to period-1, then wrap and flip phase.
            if (period_cur != '0) begin
               if (tone_cnt_q == period_cur - PERIOD_W'(1)) begin
                  tone_cnt_d = '0;
                  phase_d    = ~phase_q;
               end else begin
                  tone_cnt_d = tone_cnt_q + PERIOD_W'(1);
               end
            end

            // Duration counters.
            if (unit_last) begin
               unit_cnt_d = '0;
               mult_cnt_d = mult_last ? 4'd0 : mult_cnt_q + 4'd1;
            end else begin
               unit_cnt_d = unit_cnt_q + DUR_W'(1);
            end

            if (note_expire) begin
               if (last_slot) begin
                  if (loop_en) idx_d       = '0;
                  else         song_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         default: begin
            // FETCH and PAUSED hold everything.
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Fetch address: captured on entry to FETCH so it is stable for the
   // whole request cycle, and left untouched otherwise.
   // ------------------------------------------------------------------
   always_comb begin
      addr_d = addr_q;
      if (state_d == ST_FETCH) begin
         addr_d                      = '0;
         addr_d[IDX_W-1:0]           = idx_d;
         addr_d[IDX_W +: SONG_W]     = song_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         song_q      <= '0;
         idx_q       <= '0;
         addr_q      <= '0;
         song_done_q <= 1'b0;
         note_idx_q  <= '0;
         mult_q      <= 4'd1;
         unit_cnt_q  <= '0;
         mult_cnt_q  <= '0;
         tone_cnt_q  <= '0;
         phase_q     <= 1'b0;
      end else begin
         song_q      <= song_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         song_done_q <= song_done_d;
         note_idx_q  <= note_idx_d;
         mult_q      <= mult_d;
         unit_cnt_q  <= unit_cnt_d;
         mult_cnt_q  <= mult_cnt_d;
         tone_cnt_q  <= tone_cnt_d;
         phase_q     <= phase_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      state       = state_q;
      idle        = (state_q == ST_IDLE);
      song_done   = song_done_q;
      memreq_val  = (state_q == ST_FETCH);
      memreq_addr = addr_q;
      note_sel    = 4'd0;
      note        = 1'b0;
      if (state_q == ST_PLAY || state_q == ST_PAUSED) begin
         note_sel = note_idx_q;
      end
      if (state_q == ST_PLAY && period_cur != '0) begin
         note = phase_q;
      end
   end

endmodule
